mem_fill_arbiter: RTL and testbench

- Parametrised successor to the two-bus I/D memory controller.
- Arbitrates NUM_CH cache channels (ch0 = I-cache, ch1 = D-cache by default) for a single pipelined main memory.
- Performs block fills: issues WORDS_PER_BLOCK word reads back-to-back, streams returned words into the granted cache's data array, then writes the tag and pulses done.
- Also performs single-word write-through stores. Supports fixed-priority or round-robin arbitration.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ch_arbiter.sv | 48 ++++
 rtl/mem_fill_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cache-fill memory controller: FSM states,
// cache-side operation codes and an elaboration-time log2 helper.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        TAG   = 3'd3,
        WRITE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        READ      = 2'b00,
        DATA_FILL = 2'b01,
        TAG_FILL  = 2'b10
    } cache_op_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            res++;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_ch_arbiter.sv
// Channel arbiter: fixed priority (lowest index) or round-robin starting at
// a pointer that moves past the winner whenever an operation completes.
module mem_ch_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned RR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] winner
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             found;
    int unsigned      idx;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (RR_MODE != 0) ? ((32'(ptr) + i) % NUM_CH) : i;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                win_idx     = PTR_W'(idx);
                found       = 1'b1;
            end
        end
    end

    // While an operation runs the top feeds back only the owner, so at
    // completion the winner here is the owner and the pointer steps past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if ((RR_MODE != 0) && advance && found) begin
            ptr <= (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Multi-channel cache fill / write-through controller for one pipelined
// memory: arbitrates channels, streams block fills and performs word stores.
module mem_fill_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned RR_MODE         = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   req_valid,
    input  logic [NUM_CH-1:0]                   req_we,
    input  logic [NUM_CH*ADDR_W-1:0]            req_addr,
    input  logic [NUM_CH*DATA_W-1:0]            req_wdata,
    output logic [NUM_CH-1:0]                   grant,
    output logic                                busy,
    output logic [DATA_W-1:0]                   fill_data,
    output logic [clog2(WORDS_PER_BLOCK)-1:0]   fill_word_idx,
    output logic                                fill_data_we,
    output logic                                fill_tag_we,
    output logic [NUM_CH-1:0]                   done,
    output logic                                mem_en,
    output logic                                mem_wr,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic [DATA_W-1:0]                   mem_rdata,
    input  logic                                mem_valid
);

    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned BPW_SH = clog2(BPW);
    localparam int unsigned OFF_W  = clog2(WORDS_PER_BLOCK * BPW);
    localparam int unsigned IDX_W  = clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W  = IDX_W + 1;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);

    state_t            state;
    state_t            state_next;
    cache_op_t         cache_op;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic [NUM_CH-1:0] owner;
    logic [NUM_CH-1:0] winner;
    logic [NUM_CH-1:0] arb_req;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [ADDR_W-1:0] blk_base;
    logic [ADDR_W-1:0] rd_addr;
    logic              advance;
    logic              rx;
    logic              last_issue;
    logic              last_recv;

    assign arb_req = (state == IDLE) ? req_valid : owner;
    assign advance = (state == TAG) || (state == WRITE);

    mem_ch_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (advance),
        .winner  (winner)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (winner[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_we    = req_we[i];
            end
        end
    end

    assign blk_base   = lat_addr & ~OFF_MASK;
    assign rd_addr    = blk_base + (ADDR_W'(issue_cnt[IDX_W-1:0]) << BPW_SH);
    assign rx         = mem_valid && ((state == ISSUE) || (state == DRAIN));
    assign last_issue = (state == ISSUE) && (issue_cnt == LAST_CNT);
    assign last_recv  = rx && (recv_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With zero memory latency the final word can return in its own issue
    // cycle, so ISSUE may skip DRAIN and go straight to TAG.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = sel_we ? WRITE : ISSUE;
            ISSUE: begin
                if (last_recv)       state_next = TAG;
                else if (last_issue) state_next = DRAIN;
            end
            DRAIN:   if (last_recv)  state_next = TAG;
            TAG:     state_next = IDLE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if ((state == IDLE) && (|req_valid)) begin
                owner     <= winner;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (state == ISSUE) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (rx) begin
                recv_cnt <= recv_cnt + 1'b1;
            end
            if (advance) begin
                owner     <= '0;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
        end
    end

    always_comb begin
        grant         = '0;
        busy          = 1'b0;
        done          = '0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        fill_data     = '0;
        fill_word_idx = '0;
        cache_op      = READ;
        case (state)
            ISSUE: begin
                busy     = 1'b1;
                grant    = owner;
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end
            DRAIN: begin
                busy  = 1'b1;
                grant = owner;
            end
            TAG: begin
                busy     = 1'b1;
                grant    = owner;
                done     = owner;
                cache_op = TAG_FILL;
            end
            WRITE: begin
                busy      = 1'b1;
                grant     = owner;
                done      = owner;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            default: ;
        endcase
        if (rx) begin
            cache_op      = DATA_FILL;
            fill_data     = mem_rdata;
            fill_word_idx = recv_cnt[IDX_W-1:0];
        end
        fill_data_we = (cache_op == DATA_FILL);
        fill_tag_we  = (cache_op == TAG_FILL);
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: fixed-priority, round-robin and a
// 4-word/32-bit zero-latency instance, each with a small memory model.
module tb_mem_fill_arbiter;
    import mem_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fixed-priority instance, memory latency 3 cycles
    logic [1:0]  f_req_valid, f_req_we, f_grant, f_done;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_busy, f_fill_data_we, f_fill_tag_we, f_mem_en, f_mem_wr, f_mem_valid;
    logic [15:0] f_fill_data, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [2:0]  f_fill_word_idx;
    logic [2:0]  fv;
    logic [15:0] fd0, fd1, fd2;

    mem_fill_arbiter u_fix (
        .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_we(f_req_we),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata), .grant(f_grant), .busy(f_busy),
        .fill_data(f_fill_data), .fill_word_idx(f_fill_word_idx), .fill_data_we(f_fill_data_we),
        .fill_tag_we(f_fill_tag_we), .done(f_done), .mem_en(f_mem_en), .mem_wr(f_mem_wr),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .mem_valid(f_mem_valid)
    );

    always @(posedge clk) begin
        if (rst) fv <= '0;
        else     fv <= {fv[1:0], f_mem_en & ~f_mem_wr};
        fd0 <= ~f_mem_addr;
        fd1 <= fd0;
        fd2 <= fd1;
    end
    assign f_mem_valid = fv[2];
    assign f_mem_rdata = fd2;

    // ---------------- round-robin instance, memory latency 1 cycle
    logic [1:0]  r_req_valid, r_req_we, r_grant, r_done;
    logic [31:0] r_req_addr, r_req_wdata;
    logic        r_busy, r_fill_data_we, r_fill_tag_we, r_mem_en, r_mem_wr, r_mem_valid;
    logic [15:0] r_fill_data, r_mem_addr, r_mem_wdata, r_mem_rdata;
    logic [2:0]  r_fill_word_idx;

    mem_fill_arbiter #(.RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req_valid(r_req_valid), .req_we(r_req_we),
        .req_addr(r_req_addr), .req_wdata(r_req_wdata), .grant(r_grant), .busy(r_busy),
        .fill_data(r_fill_data), .fill_word_idx(r_fill_word_idx), .fill_data_we(r_fill_data_we),
        .fill_tag_we(r_fill_tag_we), .done(r_done), .mem_en(r_mem_en), .mem_wr(r_mem_wr),
        .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata),
        .mem_valid(r_mem_valid)
    );

    always @(posedge clk) begin
        if (rst) r_mem_valid <= 1'b0;
        else     r_mem_valid <= r_mem_en & ~r_mem_wr;
        r_mem_rdata <= ~r_mem_addr;
    end

    // ---------------- 4-word, 32-bit instance, zero-latency memory
    logic [1:0]  w_req_valid, w_req_we, w_grant, w_done;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_busy, w_fill_data_we, w_fill_tag_we, w_mem_en, w_mem_wr, w_mem_valid;
    logic [31:0] w_fill_data, w_mem_wdata, w_mem_rdata;
    logic [15:0] w_mem_addr;
    logic [1:0]  w_fill_word_idx;

    mem_fill_arbiter #(.DATA_W(32), .WORDS_PER_BLOCK(4)) u_w4 (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_we(w_req_we),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata), .grant(w_grant), .busy(w_busy),
        .fill_data(w_fill_data), .fill_word_idx(w_fill_word_idx), .fill_data_we(w_fill_data_we),
        .fill_tag_we(w_fill_tag_we), .done(w_done), .mem_en(w_mem_en), .mem_wr(w_mem_wr),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
        .mem_valid(w_mem_valid)
    );

    assign w_mem_valid = w_mem_en & ~w_mem_wr;
    assign w_mem_rdata = {16'hC0DE, w_mem_addr};

    // ---------------- checking helpers
    logic [15:0] exp_base;
    int unsigned exp_idx;
    int unsigned nfill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle on u_fix and verify any returned word against ~addr.
    task automatic step();
        logic [15:0] exp_data;
        @(negedge clk);
        if (f_fill_data_we) begin
            exp_data = ~(exp_base + 16'(2 * exp_idx));
            check("fill_idx", 64'(f_fill_word_idx), 64'(exp_idx));
            check("fill_data", 64'(f_fill_data), 64'(exp_data));
            exp_idx++;
            nfill++;
        end
    endtask

    task automatic wait_fix_done(output logic [1:0] d);
        d = '0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (f_done != 2'b00) begin
                d = f_done;
                break;
            end
        end
    endtask

    task automatic wait_rr_done(output logic [1:0] d);
        d = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (r_done != 2'b00) begin
                d = r_done;
                break;
            end
        end
    endtask

    logic [1:0] d;
    int unsigned nw;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        f_req_valid = '0; f_req_we = '0; f_req_addr = '0; f_req_wdata = '0;
        r_req_valid = '0; r_req_we = '0; r_req_addr = '0; r_req_wdata = '0;
        w_req_valid = '0; w_req_we = '0; w_req_addr = '0; w_req_wdata = '0;
        exp_base = '0; exp_idx = 0; nfill = 0; nw = 0;
        repeat (2) @(negedge clk);

        check("rst_grant", 64'(f_grant), 64'd0);
        check("rst_busy", 64'(f_busy), 64'd0);
        check("rst_mem_en", 64'(f_mem_en), 64'd0);
        check("rst_done", 64'(f_done), 64'd0);
        check("rst_fill_we", 64'({f_fill_data_we, f_fill_tag_we}), 64'd0);
        check("rst_state", 64'(u_fix.state), 64'(IDLE));
        rst = 1'b0;

        // single fill, ch1 at 0x1236
        f_req_valid = 2'b10;
        f_req_addr  = {16'h1236, 16'h0000};
        exp_base = 16'h1230; exp_idx = 0; nfill = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("issue_addr", 64'(f_mem_addr), 64'(16'h1230 + 16'(2 * i)));
            check("issue_rd", 64'({f_mem_en, f_mem_wr}), 64'b10);
            check("issue_grant", 64'(f_grant), 64'b10);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("tag_early", 64'(f_fill_tag_we), 64'd0);
        end
        step();
        check("tag_we", 64'(f_fill_tag_we), 64'd1);
        check("tag_done", 64'(f_done), 64'b10);
        f_req_valid = 2'b00;
        step();
        check("post_tag", 64'({f_fill_tag_we, f_done, f_grant, f_busy}), 64'd0);
        check("fill_count", 64'(nfill), 64'd8);

        // simultaneous fills, fixed priority
        f_req_valid = 2'b11;
        f_req_addr  = {16'h0200, 16'h0100};
        exp_base = 16'h0100; exp_idx = 0; nfill = 0;
        step();
        check("fix_first_grant", 64'(f_grant), 64'b01);
        wait_fix_done(d);
        check("fix_first_done", 64'(d), 64'b01);
        check("fix_first_count", 64'(nfill), 64'd8);
        f_req_valid = 2'b10;
        step();
        check("fix_gap_grant", 64'(f_grant), 64'b00);
        check("fix_gap_busy", 64'(f_busy), 64'd0);
        exp_base = 16'h0200; exp_idx = 0; nfill = 0;
        step();
        check("fix_second_grant", 64'(f_grant), 64'b10);
        wait_fix_done(d);
        check("fix_second_done", 64'(d), 64'b10);
        check("fix_second_count", 64'(nfill), 64'd8);
        f_req_valid = 2'b00;
        step();

        // store from ch1
        f_req_we    = 2'b10;
        f_req_addr  = {16'h0040, 16'h0000};
        f_req_wdata = {16'hBEEF, 16'h0000};
        f_req_valid = 2'b10;
        step();
        check("st_en_wr", 64'({f_mem_en, f_mem_wr}), 64'b11);
        check("st_addr", 64'(f_mem_addr), 64'h0040);
        check("st_wdata", 64'(f_mem_wdata), 64'hBEEF);
        check("st_done", 64'(f_done), 64'b10);
        check("st_no_fill", 64'({f_fill_data_we, f_fill_tag_we}), 64'd0);
        f_req_valid = 2'b00;
        f_req_we    = 2'b00;
        step();
        check("st_after", 64'({f_mem_en, f_done}), 64'd0);

        // reset at the 5th word issue, then a fresh fill
        f_req_valid = 2'b01;
        f_req_addr  = {16'h0000, 16'h0300};
        exp_base = 16'h0300; exp_idx = 0; nfill = 0;
        repeat (5) step();
        check("rst5_addr", 64'(f_mem_addr), 64'h0308);
        rst = 1'b1;
        step();
        check("rst5_ctrl", 64'({f_grant, f_busy, f_mem_en, f_mem_wr, f_done,
                                f_fill_data_we, f_fill_tag_we}), 64'd0);
        check("rst5_addr0", 64'(f_mem_addr), 64'd0);
        check("rst5_data0", 64'(f_fill_data), 64'd0);
        check("rst5_state", 64'(u_fix.state), 64'(IDLE));
        rst = 1'b0;
        exp_idx = 0; nfill = 0;
        wait_fix_done(d);
        check("rst5_refill_done", 64'(d), 64'b01);
        check("rst5_refill_count", 64'(nfill), 64'd8);
        f_req_valid = 2'b00;
        step();

        // round-robin: both requesting, owner drops for the post-done cycle
        r_req_valid = 2'b11;
        r_req_addr  = {16'h0500, 16'h0400};
        for (int k = 0; k < 4; k++) begin
            wait_rr_done(d);
            check("rr_order", 64'(d), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k < 3) begin
                r_req_valid = r_req_valid & ~d;
                @(negedge clk);
                r_req_valid = 2'b11;
            end
        end
        // ch0 store moves the pointer to ch1; then both fill requests: ch1 first
        r_req_valid = 2'b01;
        r_req_we    = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("rr_store_done", 64'(r_done), 64'b01);
        r_req_valid = 2'b00;
        r_req_we    = 2'b00;
        @(negedge clk);
        r_req_valid = 2'b11;
        @(negedge clk);
        check("rr_ptr_grant", 64'(r_grant), 64'b10);
        wait_rr_done(d);
        check("rr_ptr_done", 64'(d), 64'b10);
        r_req_valid = 2'b00;

        // 4 words x 32 bits, zero-latency returns during ISSUE
        w_req_valid = 2'b01;
        w_req_addr  = {16'h0000, 16'h0A1C};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("w4_addr", 64'(w_mem_addr), 64'(16'h0A10 + 16'(4 * i)));
            check("w4_idx", 64'(w_fill_word_idx), 64'(i));
            check("w4_data", 64'(w_fill_data), 64'({16'hC0DE, 16'h0A10 + 16'(4 * i)}));
            if (w_fill_data_we) nw++;
            @(negedge clk);
        end
        check("w4_tag", 64'(w_fill_tag_we), 64'd1);
        check("w4_done", 64'(w_done), 64'b01);
        if (w_fill_data_we) nw++;
        w_req_valid = 2'b00;
        @(negedge clk);
        check("w4_idle", 64'({w_busy, w_done, w_fill_data_we}), 64'd0);
        check("w4_we_count", 64'(nw), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of directed sequence");
        $fatal(1);
    end

endmodule
